// File: rtl/word_array_pkg.sv
// Shared defaults and state type for the
// word array serializer slice.
package word_array_pkg;

  localparam int NUM_WORDS_DEF = 6;
  localparam int WORD_W_DEF    = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/word_array_if.sv
// Packed-array input and word output handshakes
// of the word array serializer.
interface word_array_if
  import word_array_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int WORD_W    = WORD_W_DEF
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_WORDS*WORD_W-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_W-1:0]           out_data;
  logic [IDX_W-1:0]            out_idx;
  logic                        out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_idx,
    output out_last
  );

endinterface

// File: rtl/word_array_select.sv
// Picks element idx out of a packed array;
// element 0 sits in the most-significant word.
module word_array_select
  import word_array_pkg::*;
#(
  parameter  int NUM_WORDS = NUM_WORDS_DEF,
  parameter  int WORD_W    = WORD_W_DEF,
  localparam int IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic [NUM_WORDS*WORD_W-1:0] data,
  input  logic [IDX_W-1:0]            idx,
  output logic [WORD_W-1:0]           word
);

  // Mux the addressed element onto the word output
  always_comb begin
    word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == IDX_W'(i)) begin
        word = data[(NUM_WORDS-1-i)*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/word_array_serializer.sv
// Accepts one packed array of words and emits
// the words one per handshake, element 0 first.
module word_array_serializer
  import word_array_pkg::*;
#(
  parameter int NUM_WORDS = NUM_WORDS_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input logic        clk,
  input logic        rst_n,
  word_array_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int ARR_W = NUM_WORDS * WORD_W;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_WORDS - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [ARR_W-1:0]  hold;
  logic              at_last;
  logic              in_fire;
  logic              out_fire;

  word_array_select #(
    .NUM_WORDS (NUM_WORDS),
    .WORD_W    (WORD_W)
  ) u_sel (
    .data (hold),
    .idx  (idx),
    .word (bus.out_data)
  );

  assign at_last       = (idx == LAST_IDX);
  assign bus.out_valid = (state == SEND);
  assign bus.out_last  = bus.out_valid & at_last;
  assign bus.out_idx   = idx;
  // Last word frees the holding register, so
  // a new array may enter on the same edge.
  assign bus.in_ready  = (state == IDLE) |
                         (bus.out_last & bus.out_ready);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = bus.out_valid & bus.out_ready;

  // Capture arrays and step idx through the words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            hold  <= bus.in_data;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_fire) begin
            if (!at_last) begin
              idx <= idx + 1'b1;
            end else if (in_fire) begin
              hold <= bus.in_data;
              idx  <= '0;
            end else begin
              idx   <= '0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_word_array_serializer.sv
// Scoreboard bench for word_array_serializer,
// default size plus a 2 x 8-bit instance.
module tb_word_array_serializer;
  import word_array_pkg::*;

  localparam int NW = 6;
  localparam int WW = 32;
  localparam int IW = 3;

  typedef struct packed {
    logic [WW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       idx;
    logic       last;
  } sexp_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  bit   scramble;

  exp_t  exp_q[$];
  sexp_t sexp_q[$];

  word_array_if #(.NUM_WORDS(NW), .WORD_W(WW)) bus ();
  word_array_if #(.NUM_WORDS(2), .WORD_W(8)) sbus ();

  word_array_serializer #(
    .NUM_WORDS (NW),
    .WORD_W    (WW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  word_array_serializer #(
    .NUM_WORDS (2),
    .WORD_W    (8)
  ) sdut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NW*WW-1:0] pack(
    input int unsigned w[NW]
  );
    logic [NW*WW-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++)
      r[(NW-1-i)*WW +: WW] = w[i];
    return r;
  endfunction

  function automatic logic [NW*WW-1:0] rnd_arr();
    logic [NW*WW-1:0] r;
    for (int i = 0; i < NW; i++)
      r[i*WW +: WW] = $urandom;
    return r;
  endfunction

  // Present one array; expected words go to the scoreboard.
  task automatic put(input logic [NW*WW-1:0] d);
    exp_t e;
    int   n;
    for (int i = 0; i < NW; i++) begin
      e.data = d[(NW-1-i)*WW +: WW];
      e.idx  = IW'(i);
      e.last = (i == NW-1);
      exp_q.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL put_accept in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = rnd_arr();
  endtask

  // Pop and compare n words; span = cycles first..last word.
  task automatic collect(
    input  int n,
    input  bit stall,
    output int span
  );
    exp_t a;
    exp_t e;
    exp_t prev;
    bit   held;
    int   got;
    int   cyc;
    int   first;
    held  = 1'b0;
    got   = 0;
    cyc   = 0;
    first = -1;
    span  = 0;
    prev  = '0;
    while (got < n && cyc < n*4 + 20) begin
      @(negedge clk);
      cyc++;
      a = '{bus.out_data, bus.out_idx, bus.out_last};
      if (held) begin
        tests++;
        if (bus.out_valid !== 1'b1 || a !== prev) begin
          fails++;
          $display("FAIL hold_stable v=%b got=%h want=%h",
                   bus.out_valid, a, prev);
        end
      end
      if (bus.out_valid && !bus.out_last) begin
        tests++;
        if (bus.in_ready !== 1'b0) begin
          fails++;
          $display("FAIL in_ready_busy got=%b want 0", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_last) begin
        tests++;
        if (bus.in_ready !== bus.out_ready) begin
          fails++;
          $display("FAIL in_ready_last got=%b want %b",
                   bus.in_ready, bus.out_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_word got=%h want none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            fails++;
            $display("FAIL word got=%h want=%h", a, e);
          end
        end
        if (first < 0) first = cyc;
        got++;
        span = cyc - first + 1;
      end
      held = bus.out_valid && !bus.out_ready;
      prev = a;
      @(posedge clk);
      #1;
      if (stall) bus.out_ready = ~bus.out_ready;
      if (scramble && !bus.in_valid) bus.in_data = rnd_arr();
    end
    tests++;
    if (got != n) begin
      fails++;
      $display("FAIL collect_count got=%0d want=%0d", got, n);
    end
  endtask

  task automatic check_idle(input string tag);
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL %s_idle valid=%b ready=%b want 0/1",
               tag, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    sbus.in_valid = 1'b0;
    sbus.in_data  = '0;
    sbus.out_ready = 1'b1;
    scramble      = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_last} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags got=%b want 100",
               {bus.in_ready, bus.out_valid, bus.out_last});
    end
    tests++;
    if (bus.out_idx !== '0 || bus.out_data !== '0) begin
      fails++;
      $display("FAIL reset_data idx=%0d data=%h want 0/0",
               bus.out_idx, bus.out_data);
    end
    tests++;
    if ({sbus.in_ready, sbus.out_valid, sbus.out_data} !== 10'h200) begin
      fails++;
      $display("FAIL reset_small got=%h want 200",
               {sbus.in_ready, sbus.out_valid, sbus.out_data});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int span;
    bus.out_ready = 1'b1;
    put(pack('{4, 5, 4, 5, 4, 5}));
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== '0) begin
      fails++;
      $display("FAIL first_latency valid=%b idx=%0d want 1/0",
               bus.out_valid, bus.out_idx);
    end
    collect(NW, 1'b0, span);
    tests++;
    if (span != NW) begin
      fails++;
      $display("FAIL basic_span got=%0d want=%0d", span, NW);
    end
    check_idle("basic");
  endtask

  task automatic test_stall();
    int span;
    bus.out_ready = 1'b0;
    put(pack('{4, 5, 4, 5, 4, 5}));
    collect(NW, 1'b1, span);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_idle("stall");
  endtask

  task automatic test_back_to_back();
    int span;
    bus.out_ready = 1'b1;
    fork
      begin
        put(pack('{1, 2, 3, 4, 5, 6}));
        put(pack('{7, 8, 9, 10, 11, 12}));
      end
      collect(2*NW, 1'b0, span);
    join
    tests++;
    if (span != 2*NW) begin
      fails++;
      $display("FAIL b2b_span got=%0d want=%0d", span, 2*NW);
    end
    check_idle("b2b");
  endtask

  task automatic test_data_change();
    int span;
    scramble = 1'b1;
    bus.out_ready = 1'b0;
    put(rnd_arr());
    collect(NW, 1'b1, span);
    scramble = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_idle("scramble");
  endtask

  task automatic test_mid_reset();
    int span;
    bus.out_ready = 1'b1;
    put(rnd_arr());
    collect(2, 1'b0, span);
    bus.out_ready = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.out_idx !== 3'd2 || bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset idx=%0d v=%b want 2/1",
               bus.out_idx, bus.out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid, bus.out_last} !== 3'b100) begin
      fails++;
      $display("FAIL async_flags got=%b want 100",
               {bus.in_ready, bus.out_valid, bus.out_last});
    end
    tests++;
    if (bus.out_idx !== '0 || bus.out_data !== '0) begin
      fails++;
      $display("FAIL async_data idx=%0d data=%h want 0/0",
               bus.out_idx, bus.out_data);
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    put(pack('{9, 8, 7, 6, 5, 4}));
    collect(NW, 1'b0, span);
    check_idle("after_reset");
  endtask

  task automatic test_small();
    sexp_t a;
    sexp_t e;
    int    n;
    int    got;
    sexp_q.push_back('{8'hA5, 1'b0, 1'b0});
    sexp_q.push_back('{8'h5A, 1'b1, 1'b1});
    sbus.out_ready = 1'b1;
    sbus.in_valid  = 1'b1;
    sbus.in_data   = 16'hA55A;
    @(posedge clk);
    #1;
    sbus.in_valid = 1'b0;
    sbus.in_data  = 16'h1234;
    n   = 0;
    got = 0;
    while (got < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (sbus.out_valid && sbus.out_ready) begin
        a = '{sbus.out_data, sbus.out_idx, sbus.out_last};
        e = sexp_q.pop_front();
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL small_word got=%h want=%h", a, e);
        end
        got++;
      end
    end
    tests++;
    if (got != 2) begin
      fails++;
      $display("FAIL small_count got=%0d want 2", got);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_data_change();
    test_mid_reset();
    test_small();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL leftover got=%0d want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_array_serializer.md
WORD_ARRAY_SERIALIZER -- requirements
Module: word_array_serializer

Interface
REQ-001 Parameter NUM_WORDS, default 6, is the number of words per packed array; legal range 2..16.
REQ-002 Parameter WORD_W, default 32, is the width of each word in bits.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  is the reset: asynchronous and active-low.
REQ-005 in_valid  input  1  means the upstream packed array is valid.
REQ-006 in_ready  output  1  means the block accepts the array this cycle.
REQ-007 in_data  input  NUM_WORDS*WORD_W  is the packed array; element 0 occupies the most-significant WORD_W bits.
REQ-008 out_valid  output  1  means out_data holds a word.
REQ-009 out_ready  input  1  means downstream accepts the word this cycle.
REQ-010 out_data  output  WORD_W  is the current word.
REQ-011 out_idx  output  $clog2(NUM_WORDS)  is the element index of out_data.
REQ-012 out_last  output  1  is high with the word where out_idx == NUM_WORDS-1.

Function
REQ-013 Transfers occur only on cycles where valid and ready are both high at the rising edge of clk.
REQ-014 The FSM has exactly two states: IDLE and SEND.
REQ-015 In IDLE: in_ready=1, out_valid=0; an input transfer captures in_data into a holding register, sets idx=0 and moves to SEND.
REQ-016 In SEND: out_valid=1, out_data=element idx of the holding register, out_idx=idx, in_ready=0 except as REQ-019 allows.
REQ-017 Once out_valid is high, out_data, out_idx and out_last stay stable until the output transfer completes; out_valid never drops without a transfer.
REQ-018 An output transfer with idx<NUM_WORDS-1 increments idx and stays in SEND; in_data changes during SEND are ignored.
REQ-019 In SEND with out_last=1, in_ready equals out_ready, so back-to-back arrays need no bubble.
REQ-020 In the REQ-019 case, an output transfer together with an input transfer captures the new array, sets idx=0 and stays in SEND.
REQ-021 An output transfer on the last word with no input transfer returns to IDLE.
REQ-022 First word latency: out_valid is high in the cycle after the input transfer.
REQ-023 Sustained throughput is one word per cycle with out_ready held high.
REQ-024 idx never exceeds NUM_WORDS-1; no wrap beyond the last element.

Reset
REQ-025 Asserting rst_n low forces IDLE at once, including mid-array, and discards the partial array.
REQ-026 Reset values: in_ready=1, out_valid=0, out_last=0, out_idx=0, out_data=0, holding register=0.
REQ-027 The first transfer is possible at the first rising edge after rst_n deasserts.

Structure
REQ-028 A shared package word_array_pkg holds the defaults for WORD_W and NUM_WORDS and the state enum type (IDLE, SEND).
REQ-029 A single sub-module word_array_select performs the combinational extraction of element idx from the packed register; all other logic is in word_array_serializer.

Verification
REQ-030 Array {4,5,4,5,4,5} with out_ready held 1 -> out_data 4,5,4,5,4,5 on six consecutive cycles, out_idx 0..5, out_last only on the 6th word, then IDLE.
REQ-031 The same array with out_ready low on alternate cycles -> the same sequence, each word held stable while stalled, and in_ready=0 until the last word.
REQ-032 Two arrays {1..6} then {7..12} presented back-to-back with out_ready=1 -> twelve consecutive words 1..12 with no gap and out_last on words 6 and 12.
REQ-033 rst_n pulsed low while out_idx=2 -> outputs reach their reset values asynchronously; the next array starts again at out_idx=0.
REQ-034 in_data changed during SEND -> the emitted words still match the captured array.
REQ-035 NUM_WORDS=2, WORD_W=8, array 16'hA55A -> out_data 8'hA5 then 8'h5A, out_last on the second word.
